// File: rtl/lot_pkg.sv
// Shared types and default timing constants for the lot gate arbiter.
package lot_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IN  = 2'd1,
    GRANT_OUT = 2'd2,
    HOLD      = 2'd3
  } gate_state_t;

  typedef enum logic {
    IN  = 1'b0,
    OUT = 1'b1
  } side_t;

  localparam int OPEN_HOLD_DEF = 4;
  localparam int TIMEOUT_DEF   = 16;
  localparam int TW_DEF        = 5;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the grant-timeout and gate-hold phases.
module gate_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt_q <= '0;
    else if (load)                 cnt_q <= load_val;
    else if (en && (cnt_q != '0))  cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lot_gate_arbiter.sv
// Single-lane gate arbiter between entry and exit requesters; drives counter strobes.
// Optional LOT_DENY_COUNT_EN adds a saturating count of refused entry cycles.
module lot_gate_arbiter
  import lot_pkg::*;
#(
  parameter int OPEN_HOLD = OPEN_HOLD_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TW        = TW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_in,
  input  logic       req_out,
  input  logic       pass_in,
  input  logic       pass_out,
  input  logic       full,
  input  logic       clear,
  output logic       grant_in,
  output logic       grant_out,
  output logic       gate_open,
  output logic       inc,
  output logic       dec,
  output logic       timeout_err
`ifdef LOT_DENY_COUNT_EN
  ,
  input  logic       deny_clr,
  output logic [7:0] deny_cnt
`endif
);

  localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(OPEN_HOLD - 1);

  gate_state_t   state_q;
  side_t         last_q;
  logic          grant_in_q, grant_out_q, gate_q, inc_q, dec_q, tmo_q;

  logic          entry_elig, exit_elig, go_in, go_out;
  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val;

  assign entry_elig = req_in  & ~full;
  assign exit_elig  = req_out & ~clear;
  // Round-robin only matters when both sides are eligible.
  assign go_in  = entry_elig & (~exit_elig | (last_q == OUT));
  assign go_out = exit_elig & ~go_in;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_in || go_out) begin
          tmr_load = 1'b1;
          tmr_val  = TO_LD;
        end
      end
      GRANT_IN: begin
        if (pass_in) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      GRANT_OUT: begin
        if (pass_out) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      HOLD:    tmr_en = 1'b1;
      default: tmr_en = 1'b0;
    endcase
  end

  gate_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= OUT;
      grant_in_q  <= 1'b0;
      grant_out_q <= 1'b0;
      gate_q      <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_in) begin
            state_q    <= GRANT_IN;
            last_q     <= IN;
            grant_in_q <= 1'b1;
            gate_q     <= 1'b1;
          end else if (go_out) begin
            state_q     <= GRANT_OUT;
            last_q      <= OUT;
            grant_out_q <= 1'b1;
            gate_q      <= 1'b1;
          end
        end
        GRANT_IN: begin
          // A pass on the last timer cycle still wins over the timeout.
          if (pass_in) begin
            state_q    <= HOLD;
            grant_in_q <= 1'b0;
            inc_q      <= 1'b1;
          end else if (tmr_zero) begin
            state_q    <= IDLE;
            grant_in_q <= 1'b0;
            gate_q     <= 1'b0;
            tmo_q      <= 1'b1;
          end
        end
        GRANT_OUT: begin
          if (pass_out) begin
            state_q     <= HOLD;
            grant_out_q <= 1'b0;
            dec_q       <= 1'b1;
          end else if (tmr_zero) begin
            state_q     <= IDLE;
            grant_out_q <= 1'b0;
            gate_q      <= 1'b0;
            tmo_q       <= 1'b1;
          end
        end
        HOLD: begin
          if (tmr_zero) begin
            state_q <= IDLE;
            gate_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          grant_in_q  <= 1'b0;
          grant_out_q <= 1'b0;
          gate_q      <= 1'b0;
        end
      endcase
    end
  end

  assign grant_in    = grant_in_q;
  assign grant_out   = grant_out_q;
  assign gate_open   = gate_q;
  assign inc         = inc_q;
  assign dec         = dec_q;
  assign timeout_err = tmo_q;

`ifdef LOT_DENY_COUNT_EN
  logic [7:0] deny_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        deny_q <= 8'd0;
    else if (deny_clr)                                deny_q <= 8'd0;
    else if ((state_q == IDLE) && req_in && full &&
             (deny_q != 8'hFF))                       deny_q <= deny_q + 8'd1;
  end

  assign deny_cnt = deny_q;
`endif

endmodule
